// File: rtl/adder_pkg.sv
// adder_pkg: shared op type and full-adder
// helper for the pipelined ripple adder.
package adder_pkg;

  typedef enum logic {OP_ADD, OP_SUB} op_e;

  // returns {carry, sum}
  function automatic logic [1:0] fa_bit(
    input logic a,
    input logic b,
    input logic c
  );
    return {(a & b) | (c & (a ^ b)), a ^ b ^ c};
  endfunction

endpackage

// File: rtl/rca_segment.sv
// rca_segment: combinational SW-bit ripple chain.
// a,b,cin -> sum,cout; msb_c_in = carry into top bit.
module rca_segment
  import adder_pkg::*;
#(
  parameter int SW = 8
) (
  input  logic [SW-1:0] a,
  input  logic [SW-1:0] b,
  input  logic          cin,
  output logic [SW-1:0] sum,
  output logic          cout,
  output logic          msb_c_in
);

  logic [SW:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < SW; i++) begin
      {c[i+1], sum[i]} = fa_bit(a[i], b[i], c[i]);
    end
  end

  assign cout     = c[SW];
  assign msb_c_in = c[SW-1];

endmodule

// File: rtl/pipelined_ripple_adder.sv
// pipelined_ripple_adder: NSEG-stage ripple add/sub
// with valid/ready on in_* and out_* sides.
module pipelined_ripple_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NSEG  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  op_e              in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int SW = WIDTH / NSEG;
  localparam int L  = NSEG - 1;

  if (NSEG < 1 || NSEG > WIDTH ||
      (WIDTH % NSEG) != 0) begin : g_bad
    $error("WIDTH must be a multiple of NSEG");
  end

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;

  // stage k register set; the last stage
  // writes out_* instead
  logic             vq [NSEG];
  logic             cq [NSEG];
  logic [WIDTH-1:0] aq [NSEG];
  logic [WIDTH-1:0] bq [NSEG];

  logic             vn [NSEG];
  logic             cn [NSEG];
  logic [WIDTH-1:0] an [NSEG];
  logic [WIDTH-1:0] bn [NSEG];
  logic             mc [NSEG];
  logic             ovfn;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  assign b_eff = (in_op == OP_SUB) ? ~in_b : in_b;
  assign c_eff = (in_op == OP_SUB) ? 1'b1 : in_cin;

  for (genvar k = 0; k < NSEG; k++) begin : g_stg
    // aq keeps finished sum bits below the
    // segment and untouched A bits above it
    localparam logic [WIDTH-1:0] MSK =
      WIDTH'({SW{1'b1}}) << (k * SW);

    logic [WIDTH-1:0] a_s;
    logic [WIDTH-1:0] b_s;
    logic             c_s;
    logic             v_s;
    logic [SW-1:0]    s;

    if (k == 0) begin : g_src
      assign a_s = in_a;
      assign b_s = b_eff;
      assign c_s = c_eff;
      assign v_s = in_valid;
    end else begin : g_src
      assign a_s = aq[k-1];
      assign b_s = bq[k-1];
      assign c_s = cq[k-1];
      assign v_s = vq[k-1];
    end

    rca_segment #(.SW(SW)) u_seg (
      .a        (a_s[k*SW +: SW]),
      .b        (b_s[k*SW +: SW]),
      .cin      (c_s),
      .sum      (s),
      .cout     (cn[k]),
      .msb_c_in (mc[k])
    );

    assign an[k] = (a_s & ~MSK) |
                   (WIDTH'(s) << (k * SW));
    assign bn[k] = b_s;
    assign vn[k] = v_s;

    if (k == L) begin : g_ovf
      assign ovfn =
        (a_s[WIDTH-1] == b_s[WIDTH-1]) &&
        (s[SW-1] != a_s[WIDTH-1]);
    end
  end

  // msb rule must agree with carry-in/out xor
  a_ovf: assert property (
    @(posedge clk) disable iff (!rst_n)
    (adv && vn[L]) |-> (ovfn == (cn[L] ^ mc[L]))
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NSEG; k++) begin
        vq[k] <= 1'b0;
        cq[k] <= 1'b0;
        aq[k] <= '0;
        bq[k] <= '0;
      end
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
      out_ovf   <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < L; k++) begin
        vq[k] <= vn[k];
        cq[k] <= cn[k];
        aq[k] <= an[k];
        bq[k] <= bn[k];
      end
      out_valid <= vn[L];
      out_sum   <= an[L];
      out_cout  <= cn[L];
      out_ovf   <= ovfn;
    end
  end

endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// tb_pipelined_ripple_adder: three instances
// (8/2, 32/4, 8/1) against an arithmetic model.
module tb_pipelined_ripple_adder;
  import adder_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  logic        iv   [3];
  logic        ir   [3];
  logic        ov   [3];
  logic        ordy [3];
  logic        ci   [3];
  logic        co   [3];
  logic        of   [3];
  logic [31:0] ia   [3];
  logic [31:0] ib   [3];
  logic [31:0] os   [3];
  op_e         op   [3];
  logic [7:0]  os0;
  logic [31:0] os1;
  logic [7:0]  os2;
  int          wd   [3] = '{8, 32, 8};

  logic [33:0] q    [3][$];
  int          hc   [3][$];
  int          nacc [3];
  int          nout [3];

  assign os[0] = {24'd0, os0};
  assign os[1] = os1;
  assign os[2] = {24'd0, os2};

  pipelined_ripple_adder #(.WIDTH(8), .NSEG(2)) u0 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[0]), .in_ready(ir[0]),
    .in_a(ia[0][7:0]), .in_b(ib[0][7:0]),
    .in_cin(ci[0]), .in_op(op[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]),
    .out_sum(os0), .out_cout(co[0]), .out_ovf(of[0])
  );

  pipelined_ripple_adder #(.WIDTH(32), .NSEG(4)) u1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[1]), .in_ready(ir[1]),
    .in_a(ia[1]), .in_b(ib[1]),
    .in_cin(ci[1]), .in_op(op[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]),
    .out_sum(os1), .out_cout(co[1]), .out_ovf(of[1])
  );

  pipelined_ripple_adder #(.WIDTH(8), .NSEG(1)) u2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[2]), .in_ready(ir[2]),
    .in_a(ia[2][7:0]), .in_b(ib[2][7:0]),
    .in_cin(ci[2]), .in_op(op[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]),
    .out_sum(os2), .out_cout(co[2]), .out_ovf(of[2])
  );

  // {ovf, cout, sum} from plain integer arithmetic
  function automatic logic [33:0] model(
    input int          w,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic        sub,
    input logic        c
  );
    longint m, ua, ub, sa, sb, t, ss, hi, lo;
    logic   cy, ovf;
    m  = (longint'(1) << w) - 1;
    ua = longint'(a) & m;
    ub = longint'(b) & m;
    sa = a[w-1] ? ua - (longint'(1) << w) : ua;
    sb = b[w-1] ? ub - (longint'(1) << w) : ub;
    if (sub) begin
      t  = ua - ub;
      cy = (ua >= ub);
      ss = sa - sb;
    end else begin
      t  = ua + ub + longint'(c);
      cy = t[w];
      ss = sa + sb + longint'(c);
    end
    hi  = (longint'(1) << (w - 1)) - 1;
    lo  = -(longint'(1) << (w - 1));
    ovf = (ss > hi) || (ss < lo);
    return {ovf, cy, 32'(t & m)};
  endfunction

  task automatic chk(
    input string       nm,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h",
               nm, got, exp);
    end
  endtask

  // scoreboard: record accepts, check handoffs
  always @(negedge clk) begin
    logic [33:0] e;
    cyc++;
    for (int d = 0; d < 3; d++) begin
      if (!rst_n) begin
        q[d].delete();
        hc[d].delete();
        nacc[d] = 0;
        nout[d] = 0;
      end else begin
        if (iv[d] && ir[d]) begin
          q[d].push_back(model(wd[d], ia[d], ib[d],
                               op[d] == OP_SUB, ci[d]));
          nacc[d]++;
        end
        if (ov[d] && ordy[d]) begin
          nout[d]++;
          hc[d].push_back(cyc);
          if (q[d].size() == 0) begin
            total++;
            bad++;
            $display("FAIL dut%0d spurious: got %h want none",
                     d, os[d]);
          end else begin
            e = q[d].pop_front();
            chk($sformatf("dut%0d result", d),
                {30'd0, of[d], co[d], os[d]},
                {30'd0, e});
          end
        end
      end
    end
  end

  task automatic send1(
    input string      nm,
    input logic [7:0] a,
    input logic [7:0] b,
    input logic       c,
    input op_e        o,
    input logic [7:0] es,
    input logic       ec,
    input logic       eo
  );
    chk({nm, " model"},
        model(8, {24'd0, a}, {24'd0, b},
              o == OP_SUB, c),
        {eo, ec, 24'd0, es});
    @(posedge clk); #1;
    iv[0] = 1'b1;
    ia[0] = {24'd0, a};
    ib[0] = {24'd0, b};
    ci[0] = c;
    op[0] = o;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    chk({nm, " lat1"}, ov[0], 0);
    @(posedge clk); #1;
    chk({nm, " lat2"},
        {ov[0], of[0], co[0], os0},
        {1'b1, eo, ec, es});
  endtask

  task automatic stream(input int d, input int n);
    int base;
    int hb;
    int k;
    base    = nout[d];
    hb      = hc[d].size();
    ordy[d] = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      iv[d] = 1'b1;
      ia[d] = $urandom;
      ib[d] = $urandom;
      ci[d] = 1'($urandom);
      op[d] = ($urandom_range(1) == 1) ? OP_SUB : OP_ADD;
    end
    @(posedge clk); #1;
    iv[d] = 1'b0;
    k = 0;
    while (nout[d] < base + n && k < 40) begin
      @(posedge clk);
      k++;
    end
    #1;
    chk($sformatf("dut%0d stream count", d),
        nout[d] - base, n);
    if (nout[d] - base == n)
      chk($sformatf("dut%0d stream spacing", d),
          hc[d][hb+n-1] - hc[d][hb], n - 1);
  endtask

  task automatic drain(input int d);
    int k;
    k = 0;
    while (q[d].size() != 0 && k < 40) begin
      @(posedge clk);
      k++;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      iv[d]   = 1'b0;
      ordy[d] = 1'b1;
      ia[d]   = '0;
      ib[d]   = '0;
      ci[d]   = 1'b0;
      op[d]   = OP_ADD;
    end
    #2;
    for (int d = 0; d < 3; d++)
      chk($sformatf("dut%0d reset state", d),
          {ir[d], ov[d], co[d], of[d], os[d]},
          36'h8_0000_0000);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    send1("add ff+01", 8'hFF, 8'h01, 1'b0, OP_ADD,
          8'h00, 1'b1, 1'b0);
    send1("add 0f+01", 8'h0F, 8'h01, 1'b0, OP_ADD,
          8'h10, 1'b0, 1'b0);
    send1("add 7f+01", 8'h7F, 8'h01, 1'b0, OP_ADD,
          8'h80, 1'b0, 1'b1);
    send1("add 12+34+1", 8'h12, 8'h34, 1'b1, OP_ADD,
          8'h47, 1'b0, 1'b0);
    send1("add 80+80", 8'h80, 8'h80, 1'b0, OP_ADD,
          8'h00, 1'b1, 1'b1);
    send1("sub 80-01", 8'h80, 8'h01, 1'b1, OP_SUB,
          8'h7F, 1'b1, 1'b1);
    send1("sub 00-01", 8'h00, 8'h01, 1'b0, OP_SUB,
          8'hFF, 1'b0, 1'b0);
    drain(0);

    stream(0, 16);
    stream(1, 16);
    stream(2, 16);

    // fill then stall the 8/2 instance
    ordy[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      iv[0] = 1'b1;
      ia[0] = $urandom;
      ib[0] = $urandom;
      ci[0] = 1'($urandom);
      op[0] = OP_ADD;
    end
    @(posedge clk); #1;
    ordy[0] = 1'b0;
    ia[0]   = $urandom;
    #1;
    for (int j = 0; j < 3; j++) begin
      chk("stall in_ready", ir[0], 0);
      chk("stall hold",
          {30'd0, ov[0], of[0], co[0], os[0]},
          {29'd0, 1'b1, q[0][0]});
      @(posedge clk); #1;
      ia[0] = $urandom;
      ib[0] = $urandom;
    end
    ordy[0] = 1'b1;
    iv[0]   = 1'b0;
    drain(0);
    chk("stall conservation", nout[0], nacc[0]);

    // reset with two beats in flight
    @(posedge clk); #1;
    iv[0] = 1'b1;
    ia[0] = 32'h11;
    ib[0] = 32'h22;
    ci[0] = 1'b0;
    op[0] = OP_ADD;
    @(posedge clk); #1;
    ia[0] = 32'h33;
    ib[0] = 32'h44;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    chk("pre-reset valid", ov[0], 1);
    rst_n = 1'b0;
    #1;
    chk("async reset valid", ov[0], 0);
    chk("async reset sum", os0, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("post-reset idle", ov[0], 0);
    end
    send1("sub after reset", 8'h21, 8'h0F, 1'b0, OP_SUB,
          8'h12, 1'b1, 1'b0);
    drain(0);

    for (int d = 0; d < 3; d++)
      chk($sformatf("dut%0d leftover", d),
          q[d].size(), 0);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
